mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported LC-3b main memory between the CPU's instruction-fetch
//  port (read-only) and data port (read/write, byte enables). Sits between the
//  datapath's two memory interfaces and the memory model, holding a granted
//  transaction stable until mem_resp, then returning the response to its owner.
// PARAMETERS
//  STARVE_LIMIT  default 4  consecutive data grants while ifetch waits before ifetch is forced (fixed-priority mode)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  i_read          in   1   ifetch request, held high until i_resp
//  i_address       in   16  ifetch word address
//  i_resp          out  1   ifetch transaction complete (one cycle)
//  i_rdata         out  16  ifetch read data, valid with i_resp
//  d_read          in   1   data read request, held until d_resp
//  d_write         in   1   data write request, held until d_resp; never with d_read
//  d_byte_enable   in   2   data write byte lanes [1]=hi,[0]=lo
//  d_address       in   16  data address
//  d_wdata         in   16  data write data
//  d_resp          out  1   data transaction complete (one cycle)
//  d_rdata         out  16  data read data, valid with d_resp
//  mem_read        out  1   to memory
//  mem_write       out  1   to memory
//  mem_byte_enable out  2   to memory
//  mem_address     out  16  to memory
//  mem_wdata       out  16  to memory
//  mem_resp        in   1   from memory, single-cycle completion pulse
//  mem_rdata       in   16  from memory, valid with mem_resp
// BEHAVIOUR
//  - FSM states (arb_state_t): IDLE, SERVE_I, SERVE_D. Reset -> IDLE, starve_cnt=0, last_grant=I.
//  - IDLE: no request -> IDLE. Only i_read -> SERVE_I. Only d_read|d_write -> SERVE_D.
//    Both pending -> decided by policy below. Grant registered: memory sees request 1 cycle after requester.
//  - SERVE_x: mem_* driven from port x only; mem_read/mem_write derived from state AND port's
//    live request. On mem_resp -> IDLE (no back-to-back grant; IDLE cycle guarantees memory
//    sees read/write low when it returns to idle, preventing a duplicate access).
//  - IDLE outputs: mem_read=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0.
//  - i_resp = mem_resp & (state==SERVE_I); d_resp = mem_resp & (state==SERVE_D); combinational.
//    i_rdata/d_rdata = mem_rdata passthrough (don't-care without resp). SERVE_I forces mem_write=0.
//  - mem_resp in IDLE ignored (no resp to either port).
//  - Fixed priority: data wins ties. starve_cnt (clog2(STARVE_LIMIT+1) bits) increments on each
//    data grant taken while i_read pending, clears on any ifetch grant; at ==STARVE_LIMIT ifetch wins tie.
//    Saturates, never wraps.
//  - Requester dropping its request while granted is a protocol violation; arbiter returns to IDLE
//    only on mem_resp.
//  - Async reset mid-transaction: state->IDLE immediately, all mem_* low; the memory model has no
//    reset and may still pulse mem_resp, which is ignored per above.
//  - All outputs reset to 0 (resp and mem_* low).
// CONFIGURATION
//  - MEM_ARB_ROUND_ROBIN_EN defined: ties go to the port NOT in last_grant (updated on each grant);
//    starve_cnt and STARVE_LIMIT unused (counter removed).
//  - Undefined: fixed data priority with starvation limit as above.
// STRUCTURE
//  - lc3b_types: add arb_state_t {IDLE,SERVE_I,SERVE_D} and arb_port_t {ARB_I,ARB_D}; reuse lc3b_word.
//  - Sub-module mem_arb_select: combinational tie-break (inputs: i_req, d_req, last_grant,
//    starve_hit; output: next grant), so policy swaps without touching the FSM.
// TESTING
//  - i_read=1, i_address=16'h0010, memory holds 16'h1234 -> mem_read high from cycle 1,
//    i_resp with i_rdata=16'h1234 at cycle 4, d_resp never asserts.
//  - d_write be=2'b01 addr=16'h0021 wdata=16'hABCD, then d_read addr 16'h0020
//    -> only low byte written, read returns {old_hi,8'hCD}.
//  - i_read and d_read asserted same cycle (fixed mode) -> data served first, IDLE cycle, then ifetch;
//    exactly one resp per port.
//  - Both held continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,... ;
//    with MEM_ARB_ROUND_ROBIN_EN -> D,I,D,I.
//  - Assert rst_n=0 during SERVE_D wait -> mem_read/mem_write low asynchronously;
//    stray mem_resp after release yields no i_resp/d_resp.
//  - Back-to-back ifetch only -> mem_read low for exactly one cycle between transactions,
//    no duplicate access.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: types shared by the LC-3b memory arbiter.
// Defining MEM_ARB_ROUND_ROBIN_EN switches ties from fixed data priority to round-robin.
package mem_arbiter_pkg;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {ARB_I, ARB_D} arb_port_t;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit ARB_RR = 1'b1;
`else
  localparam bit ARB_RR = 1'b0;
`endif
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: picks the next grant when the arbiter is idle.
// Policy (fixed + starvation limit, or round-robin under MEM_ARB_ROUND_ROBIN_EN) lives only here.
module mem_arb_select
  import mem_arbiter_pkg::*;
(
  input  logic      i_ireq,
  input  logic      i_dreq,
  input  arb_port_t i_last_grant,
  input  logic      i_starve_hit,
  output arb_port_t o_grant
);
  logic w_tie_i;
  assign w_tie_i = i_starve_hit | (ARB_RR & (i_last_grant == ARB_D));
  assign o_grant = (i_ireq & (!i_dreq | w_tie_i)) ? ARB_I : ARB_D;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares single-ported LC-3b memory between ifetch and data ports.
// Tie-break: fixed data priority with starvation limit, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_read,
  input  lc3b_word   i_address,
  output logic       i_resp,
  output lc3b_word   i_rdata,
  input  logic       d_read,
  input  logic       d_write,
  input  logic [1:0] d_byte_enable,
  input  lc3b_word   d_address,
  input  lc3b_word   d_wdata,
  output logic       d_resp,
  output lc3b_word   d_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output lc3b_word   mem_address,
  output lc3b_word   mem_wdata,
  input  logic       mem_resp,
  input  lc3b_word   mem_rdata
);
  arb_state_t r_state, w_next;
  arb_port_t  r_last_grant, w_grant;
  logic       w_dreq, w_any, w_grant_now, w_starve_hit, w_si, w_sd;
  assign w_dreq      = d_read | d_write;
  assign w_any       = i_read | w_dreq;
  assign w_grant_now = (r_state == IDLE) & w_any;
  mem_arb_select u_select (
    .i_ireq       (i_read),
    .i_dreq       (w_dreq),
    .i_last_grant (r_last_grant),
    .i_starve_hit (w_starve_hit),
    .o_grant      (w_grant)
  );
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_starve_hit = 1'b0;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic [CW-1:0] r_starve_cnt;
  assign w_starve_hit = r_starve_cnt == LIM;
  // counts data grants that made a pending ifetch wait; saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_starve_cnt <= '0;
    else if (w_grant_now) r_starve_cnt <= (w_grant == ARB_I) ? '0 :
                                          (i_read && !w_starve_hit) ? r_starve_cnt + 1'b1 : r_starve_cnt;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ARB_I;
    end else begin
      r_state <= w_next;
      if (w_grant_now) r_last_grant <= w_grant;
    end
  end
  // always pass through IDLE after a response so memory sees read/write drop
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = !w_any ? IDLE : (w_grant == ARB_I) ? SERVE_I : SERVE_D;
    else if (mem_resp) w_next = IDLE;
  end
  always_comb begin
    w_si            = r_state == SERVE_I;
    w_sd            = r_state == SERVE_D;
    mem_read        = (w_si & i_read) | (w_sd & d_read);
    mem_write       = w_sd & d_write;
    mem_byte_enable = w_sd ? d_byte_enable : w_si ? 2'b11 : 2'b00;
    mem_address     = w_sd ? d_address : w_si ? i_address : '0;
    mem_wdata       = w_sd ? d_wdata : '0;
    i_resp          = mem_resp & w_si;
    d_resp          = mem_resp & w_sd;
    i_rdata         = mem_rdata;
    d_rdata         = mem_rdata;
  end
endmodule
